fft256_window_framer: RTL and testbench



---
 rtl/fft256_window_framer_if.sv | 13 +
 rtl/fft256_window_framer.sv | 111 +++++++++++
 tb/tb_fft256_window_framer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft256_window_framer_if.sv
// Single AXI-Stream link (data, valid, ready, last) used for both the sample input
// and the windowed output of the FFT window framer.
interface fft256_window_framer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft256_window_framer.sv
// Window-and-frame front end for the 256-point FFT: per-sample coefficient multiply with
// round/saturate, exact NUM_POINTS framing, and zero padding after an early input tlast.
module fft256_window_framer #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_FRAC  = 12,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_POINTS = 256,
    localparam int AW = $clog2(NUM_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft256_window_framer_if.slave  s_axis,
    fft256_window_framer_if.master m_axis,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [COEF_WIDTH-1:0] cfg_wdata,
    input  logic                  win_bypass,
    output logic                  frame_err,
    output logic                  dbg_state
);
    localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_POINTS - 1);
    localparam logic [COEF_WIDTH-1:0] COEF_ONE = {1'b1, {(COEF_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] RND =
        {{(PW-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if (DATA_FRAC >= DATA_WIDTH) begin : g_bad_frac
        $error("DATA_FRAC must be smaller than DATA_WIDTH");
    end

    typedef enum logic {PASS = 1'b0, PAD = 1'b1} state_t;

    state_t                        state;
    logic [AW-1:0]                 idx;
    logic                          bypass_frame;
    logic                          s1_valid;
    logic signed [DATA_WIDTH-1:0]  s1_data;
    logic                          s1_last;
    logic                          s1_bypass;
    logic [COEF_WIDTH-1:0]         coef_q;
    logic [COEF_WIDTH-1:0]         coef_ram [NUM_POINTS];
    logic                          en;
    logic                          accept;
    logic                          issue;
    logic                          eff_bypass;
    logic [COEF_WIDTH-1:0]         coef_eff;
    logic signed [PW-1:0]          prod;
    logic signed [PW-1:0]          rounded;
    logic [DATA_WIDTH-1:0]         sat_data;

    // Valid/ready: a beat transfers on a rising edge where valid && ready are both high;
    // a master holds data/last stable while valid && !ready. The whole pipeline advances
    // on en, so input ready is combinational from downstream ready.
    assign en            = !m_axis.tvalid || m_axis.tready;
    assign s_axis.tready = rst_n && en && (state == PASS);
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign issue         = accept || (en && (state == PAD));
    assign frame_err     = accept && s_axis.tlast && (idx != LAST_IDX);
    assign eff_bypass    = (idx == '0) ? win_bypass : bypass_frame;
    assign dbg_state     = (state == PAD);

    // Read-before-write: a same-address write this cycle is seen by the next read only.
    always_ff @(posedge clk) begin
        if (cfg_we) coef_ram[cfg_addr] <= cfg_wdata;
        if (en) coef_q <= coef_ram[idx];
    end

    always_comb begin
        coef_eff = s1_bypass ? COEF_ONE : coef_q;
        prod     = s1_data * $signed({1'b0, coef_eff});
        rounded  = (prod + RND) >>> (COEF_WIDTH - 1);
        if (rounded > SAT_MAX)      sat_data = SAT_MAX[DATA_WIDTH-1:0];
        else if (rounded < SAT_MIN) sat_data = SAT_MIN[DATA_WIDTH-1:0];
        else                        sat_data = rounded[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= PASS;
            idx           <= '0;
            bypass_frame  <= 1'b0;
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_last       <= 1'b0;
            s1_bypass     <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
        end else if (en) begin
            s1_valid <= issue;
            if (issue) begin
                idx       <= idx + AW'(1);
                s1_data   <= (state == PASS) ? s_axis.tdata : '0;
                s1_last   <= (idx == LAST_IDX);
                s1_bypass <= eff_bypass;
                if (idx == '0) bypass_frame <= win_bypass;
                if (state == PASS && s_axis.tlast && idx != LAST_IDX) state <= PAD;
                if (state == PAD && idx == LAST_IDX) state <= PASS;
            end
            m_axis.tvalid <= s1_valid;
            if (s1_valid) begin
                m_axis.tdata <= sat_data;
                m_axis.tlast <= s1_last;
            end
        end
    end
endmodule

// File: tb/tb_fft256_window_framer.sv
// Directed bench for fft256_window_framer: bypass ramp, half/over-unity windows,
// early-tlast padding, random output stalls and mid-frame reset.
module tb_fft256_window_framer;
  localparam int DW = 16;
  localparam int NP = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [7:0]    cfg_addr = '0;
  logic [15:0]   cfg_wdata = '0;
  logic          win_bypass = 1'b0;
  logic          frame_err;
  logic          dbg_state;

  fft256_window_framer_if #(.DATA_WIDTH(DW)) s_if ();
  fft256_window_framer_if #(.DATA_WIDTH(DW)) m_if ();

  fft256_window_framer #(
    .DATA_WIDTH(DW), .DATA_FRAC(12), .COEF_WIDTH(16), .NUM_POINTS(NP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .win_bypass(win_bypass), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic          last_acc;
  logic          last_ferr;
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] out_q[$];
  logic          out_last_q[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    #2;
    last_acc  = s_if.tvalid && s_if.tready;
    last_ferr = frame_err;
    if (rst_n && m_if.tvalid && m_if.tready) begin
      out_q.push_back(m_if.tdata);
      out_last_q.push_back(m_if.tlast);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_sample(input logic [DW-1:0] d, input logic l);
    int n = 0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    s_if.tlast  = l;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 2000);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no accept want accept of %h", d);
    end
  endtask

  task automatic drain(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load_coefs(input logic [15:0] v);
    for (int a = 0; a < NP; a++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 8'(a);
      cfg_wdata = v;
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    exp_last_q.delete();
    out_q.delete();
    out_last_q.delete();
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
    checks++; if (m_if.tdata !== 16'h0000) begin errors++; $display("FAIL reset_tdata got %h want 0000", m_if.tdata); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_if.tlast); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_if.tready); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b want 0", dbg_state); end
    rst_n = 1'b1;
    #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready got %b want 1", s_if.tready); end
  endtask

  task automatic test_bypass_ramp();
    int c0;
    clear_queues();
    win_bypass = 1'b1;
    c0 = cyc;
    for (int i = 0; i < NP; i++) begin
      if (i == 1) begin
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL ramp_latency1 got tvalid %b want 0", m_if.tvalid); end
      end
      if (i == 2) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h0000) begin
          errors++; $display("FAIL ramp_latency2 got %b/%h want 1/0000", m_if.tvalid, m_if.tdata);
        end
      end
      drive_sample(16'(i), 1'b0);
      exp_q.push_back(16'(i));
      exp_last_q.push_back(i == NP - 1);
    end
    checks++; if (cyc - c0 != NP) begin errors++; $display("FAIL ramp_throughput got %0d cycles want %0d", cyc - c0, NP); end
    drain(4);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ramp_count got %0d want %0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (out_q[i] !== exp_q[i] || out_last_q[i] !== exp_last_q[i]) begin
        errors++; $display("FAIL ramp_out[%0d] got %h/%b want %h/%b", i, out_q[i], out_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_window_half();
    logic [15:0] in_tab  [4] = '{16'h0003, 16'h8000, 16'hFFFF, 16'h7FFF};
    logic [15:0] exp_tab [4] = '{16'h0002, 16'hC000, 16'h0000, 16'h4000};
    clear_queues();
    win_bypass = 1'b0;
    load_coefs(16'h4000);
    for (int i = 0; i < NP; i++) begin
      drive_sample(in_tab[i % 4], 1'b0);
      exp_q.push_back(exp_tab[i % 4]);
      exp_last_q.push_back(i == NP - 1);
    end
    drain(4);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL half_count got %0d want %0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (out_q[i] !== exp_q[i] || out_last_q[i] !== exp_last_q[i]) begin
        errors++; $display("FAIL half_out[%0d] got %h/%b want %h/%b", i, out_q[i], out_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] in_tab  [4] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
    logic [15:0] exp_tab [4] = '{16'h7FFF, 16'h8000, 16'h0002, 16'hFFFE};
    clear_queues();
    win_bypass = 1'b0;
    load_coefs(16'hFFFF);
    for (int i = 0; i < NP; i++) begin
      drive_sample(in_tab[i % 4], 1'b0);
      exp_q.push_back(exp_tab[i % 4]);
      exp_last_q.push_back(i == NP - 1);
    end
    drain(4);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sat_count got %0d want %0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (out_q[i] !== exp_q[i] || out_last_q[i] !== exp_last_q[i]) begin
        errors++; $display("FAIL sat_out[%0d] got %h/%b want %h/%b", i, out_q[i], out_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_early_tlast();
    int ferr_cnt = 0;
    int low = 0;
    clear_queues();
    win_bypass = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_sample(16'(i + 1), i == 99);
      ferr_cnt += int'(last_ferr);
      if (i == 99) begin
        checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL early_frame_err got %b want 1", last_ferr); end
        checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL early_state_pad got %b want 1", dbg_state); end
      end
    end
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back((i < 100) ? 16'(i + 1) : 16'h0000);
      exp_last_q.push_back(i == NP - 1);
    end
    s_if.tdata  = 16'h1234;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b0;
    do begin
      tick();
      if (!last_acc) low++;
      ferr_cnt += int'(last_ferr);
    end while (!last_acc && low < 400);
    s_if.tvalid = 1'b0;
    checks++; if (low != 156) begin errors++; $display("FAIL early_pad_cycles got %0d want 156", low); end
    exp_q.push_back(16'h1234);
    exp_last_q.push_back(1'b0);
    for (int i = 1; i < NP; i++) begin
      drive_sample(16'h1234 + 16'(i), 1'b0);
      ferr_cnt += int'(last_ferr);
      exp_q.push_back(16'h1234 + 16'(i));
      exp_last_q.push_back(i == NP - 1);
    end
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL early_err_pulses got %0d want 1", ferr_cnt); end
    drain(4);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL early_count got %0d want %0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (out_q[i] !== exp_q[i] || out_last_q[i] !== exp_last_q[i]) begin
        errors++; $display("FAIL early_out[%0d] got %h/%b want %h/%b", i, out_q[i], out_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    logic stall;
    logic [DW-1:0] prev_d;
    logic prev_l;
    clear_queues();
    win_bypass = 1'b1;
    for (int i = 0; i < 3 * NP; i++) begin
      exp_q.push_back(16'(i * 37 + 5));
      exp_last_q.push_back((i % NP) == NP - 1);
    end
    for (int c = 0; c < 6000 && out_q.size() < 3 * NP; c++) begin
      s_if.tvalid = (sent < 3 * NP);
      s_if.tdata  = 16'(sent * 37 + 5);
      s_if.tlast  = 1'b0;
      m_if.tready = 1'($urandom_range(0, 1));
      #1;
      stall  = m_if.tvalid && !m_if.tready;
      prev_d = m_if.tdata;
      prev_l = m_if.tlast;
      tick();
      if (last_acc) sent++;
      if (stall) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_d || m_if.tlast !== prev_l) begin
          errors++; $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", m_if.tvalid, m_if.tdata, m_if.tlast, prev_d, prev_l);
        end
      end
    end
    m_if.tready = 1'b1;
    drain(4);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count got %0d want %0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (out_q[i] !== exp_q[i] || out_last_q[i] !== exp_last_q[i]) begin
        errors++; $display("FAIL stall_out[%0d] got %h/%b want %h/%b", i, out_q[i], out_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    win_bypass = 1'b1;
    m_if.tready = 1'b1;
    for (int i = 0; i < 130; i++) drive_sample(16'(i + 7), 1'b0);
    s_if.tdata  = 16'hBEEF;
    s_if.tvalid = 1'b1;
    rst_n = 1'b0;
    tick();
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %b want 0", m_if.tvalid); end
    checks++; if (m_if.tdata !== 16'h0000) begin errors++; $display("FAIL midrst_tdata got %h want 0000", m_if.tdata); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL midrst_tlast got %b want 0", m_if.tlast); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL midrst_tready got %b want 0", s_if.tready); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL midrst_state got %b want 0", dbg_state); end
    s_if.tvalid = 1'b0;
    rst_n = 1'b1;
    clear_queues();
    for (int i = 0; i < NP; i++) begin
      drive_sample(16'hA000 + 16'(i), 1'b0);
      exp_q.push_back(16'hA000 + 16'(i));
      exp_last_q.push_back(i == NP - 1);
    end
    drain(4);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_count got %0d want %0d", out_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (out_q[i] !== exp_q[i] || out_last_q[i] !== exp_last_q[i]) begin
        errors++; $display("FAIL midrst_out[%0d] got %h/%b want %h/%b", i, out_q[i], out_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
  endtask

  // sequence and final report
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_bypass_ramp();
    test_window_half();
    test_saturate();
    test_early_tlast();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
